// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
//   in_valid / in_data / in_ready : framed byte stream into the loader
//   mem_we / mem_addr / mem_wdata : single-cycle word write into instruction memory
// Modports:
//   master : stream source / memory side (drives bytes, observes writes)
//   slave  : the loader itself
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader: writer side of the instruction memory.
// Accepts a frame LEN_LO, LEN_HI, 4*N data bytes, CHK over a valid/ready
// byte stream, packs little-endian 32-bit words, writes them to word
// addresses 0..N-1, and releases core_hold only once the frame's
// modulo-256 data checksum matches.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           1-cycle pulse, honoured in IDLE / DONE / ERR only
//   bus             imem_loader_if.slave (byte stream in, memory write out)
//   core_hold       1 = keep core in reset (0 only in DONE)
//   busy            load in progress (LEN_LO..CHK)
//   done / error    level status of the last load
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(2 ** ADDR_W);

    // Running modulo-256 checksum of data bytes.
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_t            state_r;
    state_t            next_state_s;

    logic              in_ready_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              core_hold_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;

    logic [7:0]        len_lo_r;
    logic [ADDR_W-1:0] last_idx_r;
    logic [ADDR_W-1:0] word_idx_r;
    logic [1:0]        byte_cnt_r;
    logic [31:0]       word_r;
    logic [7:0]        sum_r;

    logic              xfer_s;
    logic              start_ok_s;
    logic [15:0]       n_s;
    logic              len_ok_s;
    logic              last_byte_s;

    assign xfer_s      = bus.in_valid & in_ready_r;
    assign start_ok_s  = start & ((state_r == ST_IDLE) | (state_r == ST_DONE) | (state_r == ST_ERR));
    assign n_s         = {bus.in_data, len_lo_r};
    assign len_ok_s    = (n_s != 16'd0) && ({1'b0, n_s} <= DEPTH_L);
    // 4th byte of the final word of the frame.
    assign last_byte_s = (byte_cnt_r == 2'd3) && (word_idx_r == last_idx_r);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a stall (no transfer) always holds the state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) next_state_s = ST_LEN_LO;
                else       next_state_s = state_r;
            end
            ST_LEN_LO: begin
                if (xfer_s) next_state_s = ST_LEN_HI;
                else        next_state_s = state_r;
            end
            ST_LEN_HI: begin
                if (xfer_s) next_state_s = len_ok_s ? ST_DATA : ST_ERR;
                else        next_state_s = state_r;
            end
            ST_DATA: begin
                if (xfer_s && last_byte_s) next_state_s = ST_CHK;
                else                       next_state_s = state_r;
            end
            ST_CHK: begin
                if (xfer_s) next_state_s = (bus.in_data == sum_r) ? ST_DONE : ST_ERR;
                else        next_state_s = state_r;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Status outputs registered from the next state so they track state_r exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            core_hold_r <= 1'b1;
        end else begin
            in_ready_r  <= (next_state_s == ST_LEN_LO) | (next_state_s == ST_LEN_HI) |
                           (next_state_s == ST_DATA)   | (next_state_s == ST_CHK);
            busy_r      <= (next_state_s == ST_LEN_LO) | (next_state_s == ST_LEN_HI) |
                           (next_state_s == ST_DATA)   | (next_state_s == ST_CHK);
            done_r      <= (next_state_s == ST_DONE);
            error_r     <= (next_state_s == ST_ERR);
            core_hold_r <= (next_state_s != ST_DONE);
        end
    end

    // Length capture, word assembly, checksum and memory write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo_r    <= 8'd0;
            last_idx_r  <= '0;
            word_idx_r  <= '0;
            byte_cnt_r  <= 2'd0;
            word_r      <= 32'd0;
            sum_r       <= 8'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
        end else begin
            mem_we_r <= 1'b0;
            if (start_ok_s) begin
                word_idx_r <= '0;
                byte_cnt_r <= 2'd0;
                word_r     <= 32'd0;
                sum_r      <= 8'd0;
                mem_addr_r <= '0;
            end else if (xfer_s) begin
                case (state_r)
                    ST_LEN_LO: len_lo_r <= bus.in_data;
                    // Only meaningful when the length is in range.
                    ST_LEN_HI: last_idx_r <= ADDR_W'(n_s - 16'd1);
                    ST_DATA: begin
                        // Shift in from the top: first byte ends up in bits 7:0.
                        word_r     <= {bus.in_data, word_r[31:8]};
                        sum_r      <= chk_add(sum_r, bus.in_data);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            mem_we_r    <= 1'b1;
                            mem_wdata_r <= {bus.in_data, word_r[31:8]};
                            mem_addr_r  <= word_idx_r;
                            // Saturate on the last word so the index never wraps.
                            if (word_idx_r != last_idx_r) word_idx_r <= word_idx_r + 1'b1;
                            else                          word_idx_r <= word_idx_r;
                        end else begin
                            mem_we_r <= 1'b0;
                        end
                    end
                    default: mem_we_r <= 1'b0;
                endcase
            end else begin
                mem_we_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign core_hold     = core_hold_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random frames
// with random valid gaps, checked against a frame-level reference model.
module tb_imem_loader;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic core_hold, busy, done, error;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [7:0]   frame_q[$];
    logic [37:0]  got_q[$];
    logic [37:0]  exp_q[$];
    bit           exp_ok;
    int           exp_consumed;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory write monitor.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) got_q.push_back({bus.mem_addr, bus.mem_wdata});
    end

    // Frame-level reference: what the loader should write and conclude.
    task automatic model();
        int n;
        int sum;
        logic [31:0] w;
        exp_q.delete();
        n = int'({frame_q[1], frame_q[0]});
        if (n < 1 || n > DEPTH) begin
            exp_ok       = 1'b0;
            exp_consumed = 2;
        end else begin
            sum = 0;
            for (int i = 0; i < n; i++) begin
                w = 32'd0;
                for (int b = 0; b < 4; b++) begin
                    w   = w | (32'(frame_q[2 + 4 * i + b]) << (8 * b));
                    sum = (sum + int'(frame_q[2 + 4 * i + b])) % 256;
                end
                exp_q.push_back({6'(i), w});
            end
            exp_ok       = (int'(frame_q[2 + 4 * n]) == sum);
            exp_consumed = 3 + 4 * n;
        end
    endtask

    task automatic build_frame(input int n, input bit bad_chk);
        int sum;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        if (n >= 1 && n <= DEPTH) begin
            sum = 0;
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                frame_q.push_back(b);
                sum = (sum + int'(b)) % 256;
            end
            if (bad_chk) frame_q.push_back(8'(sum) ^ (8'd1 << $urandom_range(7, 0)));
            else         frame_q.push_back(8'(sum));
        end
    endtask

    task automatic load_test1_frame();
        logic [7:0] f [11];
        f = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h97};
        frame_q.delete();
        foreach (f[i]) frame_q.push_back(f[i]);
    endtask

    task automatic send_bytes(input int count, input int gap_max, input int start_idx);
        int  g;
        int  t;
        bit  sent;
        for (int i = 0; i < count; i++) begin
            g = $urandom_range(gap_max, 0);
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                start        = 1'b0;
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end
            t    = 0;
            sent = 1'b0;
            while (!sent && t < 50) begin
                @(negedge clk);
                start        = (i == start_idx) && (t == 0);
                bus.in_valid = 1'b1;
                bus.in_data  = frame_q[i];
                if (bus.in_ready === 1'b1) sent = 1'b1;
                t++;
            end
            if (!sent) begin
                check_eq("in_ready_timeout", 64'd0, 64'd1);
                bus.in_valid = 1'b0;
                start        = 1'b0;
                return;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int gap_max, input int start_idx);
        model();
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        send_bytes(exp_consumed, gap_max, start_idx);
        repeat (2) @(negedge clk);
        check_eq({tag, "_done"},      64'(done),      64'(exp_ok));
        check_eq({tag, "_error"},     64'(error),     64'(!exp_ok));
        check_eq({tag, "_core_hold"}, 64'(core_hold), 64'(!exp_ok));
        check_eq({tag, "_busy"},      64'(busy),      64'd0);
        check_eq({tag, "_in_ready"},  64'(bus.in_ready), 64'd0);
        check_eq({tag, "_nwrites"},   64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) check_eq($sformatf("%s_wr%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
            else                  check_eq($sformatf("%s_wr%0d_missing", tag, i), 64'd0, 64'(exp_q[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
        check_eq({tag, "_mem_we"},    64'(bus.mem_we),    64'd0);
        check_eq({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
        check_eq({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check_eq({tag, "_core_hold"}, 64'(core_hold),     64'd1);
        check_eq({tag, "_busy"},      64'(busy),          64'd0);
        check_eq({tag, "_done"},      64'(done),          64'd0);
        check_eq({tag, "_error"},     64'(error),         64'd0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle");

        // Test 1: reference frame, valid held high; constant expectations too.
        load_test1_frame();
        run_frame("t1", 0, -1);
        check_eq("t1_w0_const", 64'(got_q.size() > 0 ? got_q[0] : 38'd0), 64'({6'd0, 32'h00500093}));
        check_eq("t1_w1_const", 64'(got_q.size() > 1 ? got_q[1] : 38'd0), 64'({6'd1, 32'h00A00113}));

        // Test 2: same frame with random gaps.
        for (int r = 0; r < 3; r++) begin
            load_test1_frame();
            run_frame("t2", 5, -1);
        end

        // Test 3: out-of-range lengths.
        frame_q = '{8'h00, 8'h00};
        run_frame("t3_len0", 2, -1);
        frame_q = '{8'h41, 8'h00};
        run_frame("t3_len65", 2, -1);

        // Test 4: bad checksum, then recovery with the correct frame.
        load_test1_frame();
        frame_q[10] = 8'h98;
        run_frame("t4_bad", 0, -1);
        load_test1_frame();
        run_frame("t4_good", 3, -1);

        // Test 5: reset after six data bytes.
        load_test1_frame();
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        send_bytes(8, 0, -1);
        reset = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        @(negedge clk);
        check_reset_outputs("t5");
        check_eq("t5_nwrites", 64'(got_q.size()), 64'd1);
        check_eq("t5_w0", 64'(got_q.size() > 0 ? got_q[0] : 38'd0), 64'({6'd0, 32'h00500093}));
        reset = 1'b0;
        @(negedge clk);

        // Test 6: start during DATA ignored; start in DONE restarts.
        load_test1_frame();
        run_frame("t6_mid", 1, 5);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("t6_restart_core_hold", 64'(core_hold),   64'd1);
        check_eq("t6_restart_busy",      64'(busy),        64'd1);
        check_eq("t6_restart_done",      64'(done),        64'd0);
        check_eq("t6_restart_in_ready",  64'(bus.in_ready), 64'd1);
        load_test1_frame();
        run_frame("t6_after", 0, -1);

        // Full-capacity frame.
        build_frame(DEPTH, 1'b0);
        run_frame("full", 0, -1);

        // Random frames.
        for (int r = 0; r < 12; r++) begin
            int kind;
            kind = $urandom_range(9, 0);
            if (kind == 0)      build_frame(0, 1'b0);
            else if (kind == 1) build_frame(DEPTH + 1 + $urandom_range(300, 0), 1'b0);
            else                build_frame($urandom_range(8, 1), kind == 2);
            run_frame($sformatf("rnd%0d", r), 4, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
